// File: rtl/axis_video_chk_pkg.sv
// ---------------------------------------------------------------------------
// axis_video_chk_pkg
// Shared types and constants for the AXI4-Stream video checker:
//   - chk_state_e  : checker FSM states
//   - ERR_*        : bit positions inside err_flags
//   - LFSR_*       : seed and tap mask of the 16-bit tready throttle LFSR
//   - lfsr16Next() : one Fibonacci step of that LFSR
// ---------------------------------------------------------------------------
package axis_video_chk_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } chk_state_e;

  localparam int ERR_SOF       = 3;
  localparam int ERR_EOL_EARLY = 2;
  localparam int ERR_EOL_LATE  = 1;
  localparam int ERR_DATA      = 0;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 expressed as a mask over bits [15:0] (bits 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Shift left, feeding back the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr16Next(input logic [15:0] state);
    logic feedback;
    feedback = ^(state & LFSR_TAPS);
    return {state[14:0], feedback};
  endfunction

endpackage

// File: rtl/lfsr16_throttle.sv
// ---------------------------------------------------------------------------
// lfsr16_throttle
// Pseudo-random ready generator used to exercise upstream backpressure.
// A free-running 16-bit Fibonacci LFSR advances every cycle; ready is
// registered and low whenever the two LSBs are both zero (about 1 in 4).
// Ports:
//   clock  : clock
//   rst_n  : asynchronous active-low reset
//   enable : ready is forced low while this is low
//   ready  : registered throttled ready
// ---------------------------------------------------------------------------
module lfsr16_throttle
  import axis_video_chk_pkg::*;
(
  input  logic clock,
  input  logic rst_n,
  input  logic enable,
  output logic ready
);

  logic [15:0] lfsr_q;
  logic        ready_q;

  // LFSR keeps running regardless of enable so the pattern is a pure
  // function of the cycle count since reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= LFSR_SEED;
      ready_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr16Next(lfsr_q);
      ready_q <= enable & (lfsr_q[1:0] != 2'b00);
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/axis_video_checker.sv
// ---------------------------------------------------------------------------
// axis_video_checker
// AXI4-Stream video sink that checks start-of-frame (tuser), end-of-line
// (tlast) and an incrementing per-line pixel pattern (pixel = column index)
// against a fixed H_ACTIVE x V_ACTIVE geometry.
// Ports:
//   clock, rst_n      : clock, asynchronous active-low reset
//   enable            : checker enable; low forces resync on next tuser
//   clr_err           : synchronous clear of err_flags, err_cnt, frame_cnt
//   axis_tdata/tvalid/tready/tuser/tlast : AXI4-Stream video slave
//   frame_done        : one-cycle pulse after the last beat of a frame
//   frame_ok          : frame had no errors; held until next frame_done
//   frame_cnt         : completed frames (wraps)
//   err_cnt           : erroneous beats (saturates)
//   err_flags         : sticky {sof, eol_early, eol_late, data}
// ---------------------------------------------------------------------------
module axis_video_checker
  import axis_video_chk_pkg::*;
#(
  parameter int DSIZE      = 24,
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter     READY_MODE = "ALWAYS"
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_err,
  input  logic [DSIZE-1:0] axis_tdata,
  input  logic             axis_tvalid,
  output logic             axis_tready,
  input  logic             axis_tuser,
  input  logic             axis_tlast,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt,
  output logic [3:0]       err_flags
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  chk_state_e        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              frameBad_q, frameBad_d;
  logic              frameDone_q, frameDone_d;
  logic              frameOk_q, frameOk_d;
  logic [15:0]       frameCnt_q, frameCnt_d;
  logic [15:0]       errCnt_q, errCnt_d;
  logic [3:0]        errFlags_q, errFlags_d;

  logic              readyRaw;
  logic              accept;
  logic              checked;
  logic              atOrigin;
  logic [XW-1:0]     posX;
  logic [YW-1:0]     posY;
  logic [DSIZE+XW-1:0] pixWide;
  logic [DSIZE-1:0]  expPix;
  logic [3:0]        beatErr;
  logic              lineEnd;
  logic              startBeat;
  logic              badNow;

  // Ready source: a registered copy of enable, or the LFSR throttle.
  if (READY_MODE == "RANDOM") begin : genRandomReady
    lfsr16_throttle uThrottle (
      .clock  (clock),
      .rst_n  (rst_n),
      .enable (enable),
      .ready  (readyRaw)
    );
  end else begin : genAlwaysReady
    logic ready_q;
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        ready_q <= 1'b0;
      end else begin
        ready_q <= enable;
      end
    end
    assign readyRaw = ready_q;
  end

  assign axis_tready = readyRaw;
  assign accept      = axis_tvalid & readyRaw;

  // A tuser beat is always evaluated as the first pixel of a frame, which
  // both locks on from WAIT_SOF and restarts a frame mid-stream.
  assign checked  = accept & ((state_q == ACTIVE) | axis_tuser);
  assign atOrigin = (x_q == '0) && (y_q == '0);
  assign posX     = axis_tuser ? '0 : x_q;
  assign posY     = axis_tuser ? '0 : y_q;

  // Expected pixel is the column index truncated/extended to DSIZE bits.
  assign pixWide  = {{DSIZE{1'b0}}, posX};
  assign expPix   = pixWide[DSIZE-1:0];

  always_comb begin
    beatErr                = 4'b0000;
    beatErr[ERR_DATA]      = (axis_tdata != expPix);
    beatErr[ERR_SOF]       = axis_tuser ? !atOrigin : atOrigin;
    beatErr[ERR_EOL_EARLY] = axis_tlast & (posX < X_LAST);
    beatErr[ERR_EOL_LATE]  = !axis_tlast & (posX == X_LAST);
  end

  // An early tlast still closes the line so the checker follows the source.
  assign lineEnd   = axis_tlast | (posX == X_LAST);
  assign startBeat = (posX == '0) && (posY == '0);
  assign badNow    = (startBeat ? 1'b0 : frameBad_q) | (|beatErr);

  // State register and all statistics.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_SOF;
      x_q         <= '0;
      y_q         <= '0;
      frameBad_q  <= 1'b0;
      frameDone_q <= 1'b0;
      frameOk_q   <= 1'b0;
      frameCnt_q  <= '0;
      errCnt_q    <= '0;
      errFlags_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frameBad_q  <= frameBad_d;
      frameDone_q <= frameDone_d;
      frameOk_q   <= frameOk_d;
      frameCnt_q  <= frameCnt_d;
      errCnt_q    <= errCnt_d;
      errFlags_q  <= errFlags_d;
    end
  end

  // Next-state logic. clr_err is applied to the defaults first so that an
  // error on the same beat is recorded on top of the cleared statistics.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    frameBad_d  = frameBad_q;
    frameDone_d = 1'b0;
    frameOk_d   = frameOk_q;
    frameCnt_d  = clr_err ? 16'h0000 : frameCnt_q;
    errCnt_d    = clr_err ? 16'h0000 : errCnt_q;
    errFlags_d  = clr_err ? 4'b0000  : errFlags_q;

    if (!enable) begin
      state_d    = WAIT_SOF;
      x_d        = '0;
      y_d        = '0;
      frameBad_d = 1'b0;
    end else if (checked) begin
      state_d    = ACTIVE;
      errFlags_d = errFlags_d | beatErr;
      if ((|beatErr) && (errCnt_d != 16'hFFFF)) begin
        errCnt_d = errCnt_d + 16'd1;
      end

      if (lineEnd) begin
        x_d = '0;
        if (posY == Y_LAST) begin
          y_d         = '0;
          frameDone_d = 1'b1;
          frameOk_d   = !badNow;
          frameCnt_d  = frameCnt_d + 16'd1;
          frameBad_d  = 1'b0;
        end else begin
          y_d        = posY + YW'(1);
          frameBad_d = badNow;
        end
      end else begin
        x_d        = posX + XW'(1);
        y_d        = posY;
        frameBad_d = badNow;
      end
    end
  end

  assign frame_done = frameDone_q;
  assign frame_ok   = frameOk_q;
  assign frame_cnt  = frameCnt_q;
  assign err_cnt    = errCnt_q;
  assign err_flags  = errFlags_q;

endmodule

// File: tb/tb_axis_video_checker.sv
// ---------------------------------------------------------------------------
// tb_axis_video_checker
// Directed bench for axis_video_checker with an 8x4 geometry and 8-bit
// pixels. Instance A runs with ready always asserted, instance B with the
// LFSR throttle. A table of single-fault frames drives instance A; the
// multi-cycle corner cases are written out as sequences.
// ---------------------------------------------------------------------------
module tb_axis_video_checker;

  localparam int DW = 8;
  localparam int H  = 8;
  localparam int V  = 4;

  localparam int K_NONE  = 0;
  localparam int K_DATA  = 1;
  localparam int K_EARLY = 2;
  localparam int K_LATE  = 3;
  localparam int K_NOSOF = 4;
  localparam int K_CLR   = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A (ALWAYS) signals
  logic          rstnA, enA, clrA, validA, userA, lastA;
  logic [DW-1:0] dataA;
  logic          readyA, doneA, okA;
  logic [15:0]   fcntA, ecntA;
  logic [3:0]    flagsA;

  // Instance B (RANDOM) signals
  logic          rstnB, enB, clrB, validB, userB, lastB;
  logic [DW-1:0] dataB;
  logic          readyB, doneB, okB;
  logic [15:0]   fcntB, ecntB;
  logic [3:0]    flagsB;

  axis_video_checker #(
    .DSIZE(DW), .H_ACTIVE(H), .V_ACTIVE(V), .READY_MODE("ALWAYS")
  ) dutA (
    .clock(clock), .rst_n(rstnA), .enable(enA), .clr_err(clrA),
    .axis_tdata(dataA), .axis_tvalid(validA), .axis_tready(readyA),
    .axis_tuser(userA), .axis_tlast(lastA),
    .frame_done(doneA), .frame_ok(okA), .frame_cnt(fcntA),
    .err_cnt(ecntA), .err_flags(flagsA)
  );

  axis_video_checker #(
    .DSIZE(DW), .H_ACTIVE(H), .V_ACTIVE(V), .READY_MODE("RANDOM")
  ) dutB (
    .clock(clock), .rst_n(rstnB), .enable(enB), .clr_err(clrB),
    .axis_tdata(dataB), .axis_tvalid(validB), .axis_tready(readyB),
    .axis_tuser(userB), .axis_tlast(lastB),
    .frame_done(doneB), .frame_ok(okB), .frame_cnt(fcntB),
    .err_cnt(ecntB), .err_flags(flagsB)
  );

  int   errors = 0;
  int   checks = 0;
  int   doneCntA = 0;
  int   doneCntB = 0;
  logic okLogA [64];
  logic okLogB [64];
  bit   measure = 1'b0;
  int   lowCyc = 0;
  int   totCyc = 0;

  // Record every frame_done pulse and the frame_ok that came with it, and
  // count throttled cycles while a measurement window is open.
  always @(negedge clock) begin
    if (doneA === 1'b1) begin
      if (doneCntA < 64) okLogA[doneCntA] = okA;
      doneCntA++;
    end
    if (doneB === 1'b1) begin
      if (doneCntB < 64) okLogB[doneCntB] = okB;
      doneCntB++;
    end
    if (measure) begin
      totCyc++;
      if (readyB !== 1'b1) lowCyc++;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Offer one beat and wait (bounded) for it to be accepted. clr is raised
  // only in the cycle the beat is actually accepted.
  task automatic sendBeat(input bit rnd, input logic [DW-1:0] d, input logic u,
                          input logic l, input logic c);
    bit got;
    got = 1'b0;
    @(negedge clock);
    if (rnd) begin
      dataB = d; userB = u; lastB = l; validB = 1'b1; clrB = 1'b0;
    end else begin
      dataA = d; userA = u; lastA = l; validA = 1'b1; clrA = 1'b0;
    end
    for (int t = 0; t < 64; t++) begin
      if ((rnd && readyB === 1'b1) || (!rnd && readyA === 1'b1)) begin
        if (rnd) clrB = c; else clrA = c;
        @(posedge clock);
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL beatTimeout: got no ready required ready within 64 cycles");
    end
  endtask

  task automatic idle(input bit rnd, input int n);
    @(negedge clock);
    if (rnd) begin validB = 1'b0; clrB = 1'b0; userB = 1'b0; lastB = 1'b0; end
    else     begin validA = 1'b0; clrA = 1'b0; userA = 1'b0; lastA = 1'b0; end
    repeat (n - 1) @(negedge clock);
  endtask

  task automatic clearStats(input bit rnd);
    @(negedge clock);
    if (rnd) clrB = 1'b1; else clrA = 1'b1;
    @(negedge clock);
    if (rnd) clrB = 1'b0; else clrA = 1'b0;
  endtask

  // Send one full frame with at most one kind of fault.
  task automatic applyStimulus(input bit rnd, input int kind, input int fx, input int fy);
    logic [DW-1:0] d;
    logic          u, l, c;
    bit            hit;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        d   = DW'(x);
        u   = (x == 0 && y == 0 && kind != K_NOSOF);
        l   = (x == H - 1);
        c   = 1'b0;
        hit = (x == fx && y == fy);
        if (kind == K_DATA && hit) d = 8'h55;
        if (kind == K_LATE && hit) l = 1'b0;
        if (kind == K_EARLY && hit) l = 1'b1;
        if (kind == K_CLR) begin
          if (x == 1 && y == 0) d = 8'h55;
          if (hit) begin d = 8'h55; c = 1'b1; end
        end
        sendBeat(rnd, d, u, l, c);
        if (kind == K_EARLY && hit) break;
      end
    end
  endtask

  typedef struct {
    string name;
    int    kind;
    int    fx;
    int    fy;
    int    nFrames;
    int    expFlags;
    int    expErr;
    int    expDones;
    int    expFirstOk;
    int    expLastOk;
    int    expFcnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base;
    int pct;

    vecs[0] = '{"clean3",  K_NONE,  0, 0, 3, 4'b0000, 0, 3, 1, 1, 3};
    vecs[1] = '{"data52",  K_DATA,  5, 2, 2, 4'b0001, 1, 2, 0, 1, 2};
    vecs[2] = '{"early31", K_EARLY, 3, 1, 1, 4'b0100, 1, 1, 0, 0, 1};
    vecs[3] = '{"late70",  K_LATE,  7, 0, 1, 4'b0010, 1, 1, 0, 0, 1};
    vecs[4] = '{"nosof",   K_NOSOF, 0, 0, 1, 4'b1000, 1, 1, 0, 0, 1};
    vecs[5] = '{"data03",  K_DATA,  0, 3, 1, 4'b0001, 1, 1, 0, 0, 1};

    rstnA = 1'b0; enA = 1'b0; clrA = 1'b0; validA = 1'b0; userA = 1'b0; lastA = 1'b0; dataA = '0;
    rstnB = 1'b0; enB = 1'b0; clrB = 1'b0; validB = 1'b0; userB = 1'b0; lastB = 1'b0; dataB = '0;
    repeat (2) @(negedge clock);

    // Reset values
    checkOutput("rstReadyA", int'(readyA), 0);
    checkOutput("rstDoneA",  int'(doneA),  0);
    checkOutput("rstOkA",    int'(okA),    0);
    checkOutput("rstFcntA",  int'(fcntA),  0);
    checkOutput("rstEcntA",  int'(ecntA),  0);
    checkOutput("rstFlagsA", int'(flagsA), 0);
    checkOutput("rstReadyB", int'(readyB), 0);

    // Ready follows enable one cycle later
    rstnA = 1'b1; rstnB = 1'b1; enA = 1'b1; enB = 1'b1;
    #1;
    checkOutput("readyLatency0", int'(readyA), 0);
    @(negedge clock);
    checkOutput("readyLatency1", int'(readyA), 1);

    // Startup garbage without tuser is discarded, then one clean frame
    for (int i = 0; i < 10; i++) sendBeat(1'b0, DW'(i * 7 + 3), 1'b0, (i == 4), 1'b0);
    applyStimulus(1'b0, K_NONE, 0, 0);
    idle(1'b0, 3);
    checkOutput("garbageErr",   int'(ecntA),  0);
    checkOutput("garbageFlags", int'(flagsA), 0);
    checkOutput("garbageFcnt",  int'(fcntA),  1);
    checkOutput("garbageDones", doneCntA,     1);
    checkOutput("garbageOk",    int'(okLogA[0]), 1);

    // Table of single-fault frames
    for (int v = 0; v < 6; v++) begin
      clearStats(1'b0);
      checkOutput({vecs[v].name, "_clrErr"},  int'(ecntA), 0);
      checkOutput({vecs[v].name, "_clrFcnt"}, int'(fcntA), 0);
      base = doneCntA;
      for (int f = 0; f < vecs[v].nFrames; f++) begin
        applyStimulus(1'b0, (f == 0) ? vecs[v].kind : K_NONE, vecs[v].fx, vecs[v].fy);
      end
      idle(1'b0, 3);
      checkOutput({vecs[v].name, "_flags"}, int'(flagsA), vecs[v].expFlags);
      checkOutput({vecs[v].name, "_err"},   int'(ecntA),  vecs[v].expErr);
      checkOutput({vecs[v].name, "_fcnt"},  int'(fcntA),  vecs[v].expFcnt);
      checkOutput({vecs[v].name, "_dones"}, doneCntA - base, vecs[v].expDones);
      if (doneCntA > base && doneCntA <= 64) begin
        checkOutput({vecs[v].name, "_firstOk"}, int'(okLogA[base]),         vecs[v].expFirstOk);
        checkOutput({vecs[v].name, "_lastOk"},  int'(okLogA[doneCntA - 1]), vecs[v].expLastOk);
      end
    end

    // Mid-frame tuser at (4,2): aborted frame gives no frame_done, the
    // restarted frame completes normally
    clearStats(1'b0);
    base = doneCntA;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < H; x++) sendBeat(1'b0, DW'(x), (x == 0 && y == 0), (x == H - 1), 1'b0);
    for (int x = 0; x < 4; x++) sendBeat(1'b0, DW'(x), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, K_NONE, 0, 0);
    idle(1'b0, 3);
    checkOutput("restartFlags", int'(flagsA), 4'b1000);
    checkOutput("restartErr",   int'(ecntA),  1);
    checkOutput("restartFcnt",  int'(fcntA),  1);
    checkOutput("restartDones", doneCntA - base, 1);

    // Asynchronous reset mid-frame
    clearStats(1'b0);
    for (int x = 0; x < H; x++) sendBeat(1'b0, (x == 2) ? 8'h55 : DW'(x), (x == 0), (x == H - 1), 1'b0);
    @(negedge clock);
    validA = 1'b0;
    checkOutput("preResetErr", int'(ecntA), 1);
    #2 rstnA = 1'b0;
    #1;
    checkOutput("asyncRstErr",   int'(ecntA),  0);
    checkOutput("asyncRstFlags", int'(flagsA), 0);
    checkOutput("asyncRstReady", int'(readyA), 0);
    @(negedge clock);
    rstnA = 1'b1;
    base = doneCntA;
    applyStimulus(1'b0, K_NONE, 0, 0);
    idle(1'b0, 3);
    checkOutput("postRstErr",   int'(ecntA),  0);
    checkOutput("postRstFcnt",  int'(fcntA),  1);
    checkOutput("postRstDones", doneCntA - base, 1);

    // RANDOM mode: two clean frames under throttling
    measure = 1'b1;
    applyStimulus(1'b1, K_NONE, 0, 0);
    applyStimulus(1'b1, K_NONE, 0, 0);
    measure = 1'b0;
    idle(1'b1, 3);
    checkOutput("rndDones", doneCntB, 2);
    checkOutput("rndFcnt",  int'(fcntB), 2);
    checkOutput("rndErr",   int'(ecntB), 0);
    pct = (totCyc > 0) ? (lowCyc * 100) / totCyc : 0;
    checkOutput("rndReadyLowPctInRange", int'(pct >= 5 && pct <= 50), 1);

    // clr_err on the same beat as a data error: clear first, then record
    applyStimulus(1'b1, K_CLR, 5, 2);
    idle(1'b1, 3);
    checkOutput("clrSameErr",   int'(ecntB),  1);
    checkOutput("clrSameFlags", int'(flagsB), 4'b0001);
    checkOutput("clrSameFcnt",  int'(fcntB),  1);
    if (doneCntB == 3) checkOutput("clrSameOk", int'(okLogB[2]), 0);
    else               checkOutput("clrSameDones", doneCntB, 3);

    // Drop enable mid-frame, then resynchronise on the next tuser
    for (int x = 0; x < H; x++) sendBeat(1'b1, DW'(x), (x == 0), (x == H - 1), 1'b0);
    for (int x = 0; x < 3; x++) sendBeat(1'b1, DW'(x), 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    enB = 1'b0;
    @(negedge clock);
    checkOutput("enDropReady", int'(readyB), 0);
    repeat (3) @(negedge clock);
    enB = 1'b1;
    for (int i = 0; i < 5; i++) sendBeat(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, K_NONE, 0, 0);
    idle(1'b1, 3);
    checkOutput("resyncErr",   int'(ecntB),  1);
    checkOutput("resyncFlags", int'(flagsB), 4'b0001);
    checkOutput("resyncFcnt",  int'(fcntB),  2);
    checkOutput("resyncDones", doneCntB,     4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_video_checker.md
# axis_video_checker

Downstream sink for the AXI4-Stream video produced by the test-pattern generator and its native-to-AXIS stage. It accepts one pixel per beat and checks the start-of-frame flag (`axis_tuser`), the end-of-line flag (`axis_tlast`), and the per-line incrementing test pattern against the expected geometry. It reports per-frame pass/fail, frame and error counts, and sticky error flags. It can throttle `axis_tready` to exercise upstream backpressure.

## Interface
- `DSIZE`, 24, pixel/tdata width
- `H_ACTIVE`, 1920, pixels per line (≥2)
- `V_ACTIVE`, 1080, lines per frame (≥1)
- `READY_MODE`, "ALWAYS", "ALWAYS" or "RANDOM" (LFSR-throttled tready)

Ports:
- `clock` in 1: single clock
- `rst_n` in 1: asynchronous active-low reset
- `enable` in 1: checker enable
- `clr_err` in 1: synchronous clear of `err_flags`, `err_cnt`, `frame_cnt`
- `axis_tdata` in DSIZE: pixel
- `axis_tvalid` in 1: beat valid
- `axis_tready` out 1: beat ready (registered)
- `axis_tuser` in 1: start of frame
- `axis_tlast` in 1: end of line
- `frame_done` out 1: one-cycle pulse, frame completed
- `frame_ok` out 1: frame had zero errors; valid with `frame_done`, held until next `frame_done`
- `frame_cnt` out 16: completed frames, wraps
- `err_cnt` out 16: erroneous beats, saturates at 16'hFFFF
- `err_flags` out 4: sticky {sof, eol_early, eol_late, data}

## Operation
- Accept = `axis_tvalid & axis_tready`. Nothing is evaluated on non-accepted cycles.
- The expected pixel at column x is `x[DSIZE-1:0]`. It restarts at 0 on every line.
- States:
  - WAIT_SOF: entered on reset or when `enable` is low.
    - Beats without tuser are accepted and discarded silently.
    - A beat with tuser → ACTIVE. That beat is checked as (x=0, y=0).
  - ACTIVE: x/y counters advance per accepted beat.
- Per-beat checks in ACTIVE. Each failing beat increments `err_cnt` by 1 at most, and marks the frame bad.
  - data: tdata ≠ x.
  - sof:
    - tuser=1 at (x,y)≠(0,0): this beat restarts the frame as (0,0). The aborted frame produces no `frame_done`.
    - tuser=0 at (0,0): error, counting continues.
  - eol_early: tlast=1 with x<H_ACTIVE-1. Next beat is x=0, y+1.
  - eol_late: tlast=0 at x=H_ACTIVE-1. x still wraps to 0.
- At x=H_ACTIVE-1 (or early tlast) with y=V_ACTIVE-1, the frame ends:
  - `frame_done` pulses.
  - `frame_ok` = no error in that frame.
  - `frame_cnt`+1.
  - x=y=0, and the state stays ACTIVE, expecting tuser on the next beat.
- `enable` low:
  - `axis_tready` drops next cycle.
  - State → WAIT_SOF, x/y cleared.
  - Statistics are kept.
- `clr_err` together with an error beat in the same cycle: the clear applies first, then the error is recorded (flag set, `err_cnt`=1).
- RANDOM mode:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advancing every cycle.
  - `axis_tready` = `enable & (lfsr[1:0]≠0)`, registered.
- ALWAYS mode: `axis_tready` = registered `enable`.

## Timing
- Reset values: `axis_tready`=0, `frame_done`=0, `frame_ok`=0, `frame_cnt`=0, `err_cnt`=0, `err_flags`=0, state WAIT_SOF, LFSR=seed.
- `axis_tready` follows `enable` with 1-cycle latency.
- `err_flags`/`err_cnt` update 1 cycle after the offending beat.
- `frame_done`/`frame_ok`/`frame_cnt` update 1 cycle after the last beat of the frame.
- Asynchronous reset mid-frame returns everything to reset values immediately. The partial frame is forgotten.
- Back-to-back frames with no idle cycles are supported at full rate (1 beat/cycle).

## Structure
- Package `axis_video_chk_pkg`:
  - state enum {WAIT_SOF, ACTIVE}
  - err_flags bit indices (SOF=3, EOL_EARLY=2, EOL_LATE=1, DATA=0)
  - LFSR seed and tap constants
- Sub-module `lfsr16_throttle` (clock, rst_n, enable → ready), instantiated only when READY_MODE="RANDOM".

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=4, DSIZE=8.
- Clean frames: 3 frames, data 0..7 per line, tuser on beat 0, tlast on x=7 → 3 `frame_done` pulses, `frame_ok`=1 each, `frame_cnt`=3, `err_cnt`=0.
- Data error: line 2, x=5 carries 8'h55 → `err_flags`=4'b0001, `err_cnt`=1, that frame's `frame_ok`=0, next clean frame `frame_ok`=1.
- Early tlast at x=3 on line 1 → `err_flags`[2]=1. Frame ends after y=3 line, `frame_done` still fires.
- Mid-frame tuser at (4,2) → `err_flags`[3]=1. No `frame_done` for the aborted frame. A complete frame from that beat gives `frame_done`.
- Startup garbage: 10 beats without tuser, then a clean frame → no errors, `frame_cnt`=1.
- RANDOM mode with a continuously valid source: `axis_tready` low ~25% of cycles, 2 clean frames pass. Assert `clr_err` while a data error is injected in the same cycle → `err_cnt`=1. Drop `enable` mid-frame → `axis_tready`=0 next cycle, and the checker resynchronises on the next tuser.
